instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory fetch port in the multi-cycle RISC core.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/ifu_pc_reg.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// S_FAULT is only part of the encoding when IFU_ALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam int          PC_STEP          = 2;
    localparam int          INSTR_W_DEF      = 16;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } ifu_state_e;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1
    } ifu_state_e;
`endif

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: async reset to RESET_PC, redirect load, fixed-step increment.
module ifu_pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Load wins over increment; increment wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fixed-latency fetch, IR valid/ready hold, redirects.
// Optional IFU_ALIGN_CHECK_EN: odd redirect targets raise a sticky fault and halt fetching.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                MEM_WAIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               misalign_fault
);

    ifu_state_e         state_q,    state_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;
    logic [INSTR_W-1:0] ir_q,       ir_d;
    logic [ADDR_W-1:0]  ir_pc_q,    ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               fault_q,    fault_d;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  target_even;
    logic               pc_load_en;
    logic               pc_inc;
    logic               in_fault;
    logic               bad_target;

    assign target_even = pc_target & ~ADDR_W'(1);

`ifdef IFU_ALIGN_CHECK_EN
    assign in_fault   = (state_q == S_FAULT);
    assign bad_target = pc_target[0];
`else
    assign in_fault   = 1'b0;
    assign bad_target = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        pc_load_en = 1'b0;
        pc_inc     = 1'b0;
        if (!in_fault) begin
            if (pc_load) begin
                // A redirect discards any capture or handoff happening this cycle.
                ir_valid_d = 1'b0;
                wait_cnt_d = '0;
                if (bad_target) begin
                    fault_d = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
                    state_d = S_FAULT;
`endif
                end else begin
                    pc_load_en = 1'b1;
                    state_d    = S_FETCH;
                end
            end else if (state_q == S_HOLD) begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end else if (fetch_en) begin
                if (wait_cnt_q == 3'(MEM_WAIT)) begin
                    ir_d       = mem_instr;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    wait_cnt_d = '0;
                    pc_inc     = 1'b1;
                    state_d    = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

    ifu_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load_en),
        .load_val (target_even),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign mem_addr       = pc;
    assign ir             = ir_q;
    assign ir_pc          = ir_pc_q;
    assign ir_valid       = ir_valid_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two instances (MEM_WAIT 0 and 3) share stimulus and
// are checked every cycle against a transaction-level model, plus literal directed checks.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        ir_ready;

    logic [15:0] addr_a, instr_a, ir_a, irpc_a;
    logic        valid_a, fault_a;
    logic [15:0] addr_b, instr_b, ir_b, irpc_b;
    logic        valid_b, fault_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(logic [15:0] a);
        case (a)
            16'd0:   return 8'h50;
            16'd1:   return 8'h12;
            16'd2:   return 8'h70;
            16'd3:   return 8'hF2;
            16'd4:   return 8'h16;
            16'd5:   return 8'h24;
            16'd6:   return 8'h64;
            16'd7:   return 8'h36;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return {mem_byte(a + 16'd1), mem_byte(a)};
    endfunction

    assign instr_a = mem_word(addr_a);
    assign instr_b = mem_word(addr_b);

    instruction_fetch_unit #(.MEM_WAIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_load(pc_load),
        .pc_target(pc_target), .mem_addr(addr_a), .mem_instr(instr_a), .ir(ir_a),
        .ir_pc(irpc_a), .ir_valid(valid_a), .ir_ready(ir_ready), .misalign_fault(fault_a)
    );

    instruction_fetch_unit #(.MEM_WAIT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_load(pc_load),
        .pc_target(pc_target), .mem_addr(addr_b), .mem_instr(instr_b), .ir(ir_b),
        .ir_pc(irpc_b), .ir_valid(valid_b), .ir_ready(ir_ready), .misalign_fault(fault_b)
    );

    // Transaction-level model: count enabled cycles spent waiting; an instruction
    // arrives once MEM_WAIT+1 of them have elapsed since the fetch began.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] ir_pc;
        bit          valid;
        bit          fault;
        int          waited;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t r;
        r.pc = 16'h0000; r.ir = 16'h0000; r.ir_pc = 16'h0000;
        r.valid = 1'b0; r.fault = 1'b0; r.waited = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int wt, bit fe, bit pl, logic [15:0] tgt, bit rdy);
        mdl_t n = s;
        if (s.fault) return n;
        if (pl) begin
`ifdef IFU_ALIGN_CHECK_EN
            if (tgt[0]) begin
                n.valid = 1'b0;
                n.fault = 1'b1;
                return n;
            end
`endif
            n.pc     = {tgt[15:1], 1'b0};
            n.valid  = 1'b0;
            n.waited = 0;
            return n;
        end
        if (s.valid) begin
            if (rdy) n.valid = 1'b0;
            return n;
        end
        if (fe) begin
            n.waited = s.waited + 1;
            if (n.waited == wt + 1) begin
                n.ir     = mem_word(s.pc);
                n.ir_pc  = s.pc;
                n.pc     = s.pc + 16'd2;
                n.valid  = 1'b1;
                n.waited = 0;
            end
        end
        return n;
    endfunction

    mdl_t ma = mreset();
    mdl_t mb = mreset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, 0, fetch_en, pc_load, pc_target, ir_ready);
            mb <= mstep(mb, 3, fetch_en, pc_load, pc_target, ir_ready);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string p, mdl_t m, logic [15:0] addr, logic v,
                       logic [15:0] ir, logic [15:0] irpc, logic f);
        chk({p, "_mem_addr"}, 32'(addr), 32'(m.pc));
        chk({p, "_ir_valid"}, 32'(v), 32'(m.valid));
        chk({p, "_fault"}, 32'(f), 32'(m.fault));
        if (m.valid) begin
            chk({p, "_ir"}, 32'(ir), 32'(m.ir));
            chk({p, "_ir_pc"}, 32'(irpc), 32'(m.ir_pc));
        end
    endtask

    always @(negedge clk) begin
        cmp("mdl_a", ma, addr_a, valid_a, ir_a, irpc_a, fault_a);
        cmp("mdl_b", mb, addr_b, valid_b, ir_b, irpc_b, fault_b);
    end

    task automatic do_reset();
        rst_n = 1'b0; fetch_en = 1'b0; pc_load = 1'b0; pc_target = 16'h0; ir_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] seq_ir [4] = '{16'h1250, 16'hF270, 16'h2416, 16'h3664};

    initial begin
        do_reset();
        chk("reset_addr_a", 32'(addr_a), 32'h0);
        chk("reset_valid_a", 32'(valid_a), 32'h0);
        chk("reset_fault_b", 32'(fault_b), 32'h0);

        // MEM_WAIT=0 streaming with ready held high.
        fetch_en = 1'b1; ir_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("seq_valid", 32'(valid_a), 32'h1);
                chk("seq_ir", 32'(ir_a), 32'(seq_ir[k / 2]));
                chk("seq_ir_pc", 32'(irpc_a), 32'(2 * (k / 2)));
            end else begin
                chk("seq_gap", 32'(valid_a), 32'h0);
            end
        end

        // MEM_WAIT=3 hold with ready low.
        do_reset();
        fetch_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait3_early", 32'(valid_b), 32'h0);
        @(negedge clk);
        chk("wait3_valid", 32'(valid_b), 32'h1);
        chk("wait3_ir", 32'(ir_b), 32'h1250);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(valid_b), 32'h1);
            chk("hold_ir", 32'(ir_b), 32'h1250);
            chk("hold_addr", 32'(addr_b), 32'h2);
        end
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        chk("release_drop", 32'(valid_b), 32'h0);
        repeat (3) @(negedge clk);
        chk("release_wait", 32'(valid_b), 32'h0);
        @(negedge clk);
        chk("release_ir", 32'(ir_b), 32'hF270);
        chk("release_valid", 32'(valid_b), 32'h1);

        // fetch_en freeze mid-wait on the MEM_WAIT=3 instance.
        do_reset();
        fetch_en = 1'b1;
        repeat (2) @(negedge clk);
        fetch_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("freeze_no_cap", 32'(valid_b), 32'h0);
        end
        fetch_en = 1'b1;
        @(negedge clk);
        chk("resume_wait", 32'(valid_b), 32'h0);
        @(negedge clk);
        chk("resume_cap", 32'(valid_b), 32'h1);
        chk("resume_ir", 32'(ir_b), 32'h1250);

        // Redirect from hold, then wrap at the top of memory.
        do_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        chk("redir_pre", 32'(ir_a), 32'h1250);
        pc_load = 1'b1; pc_target = 16'h0006; ir_ready = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        chk("redir_drop", 32'(valid_a), 32'h0);
        chk("redir_addr", 32'(addr_a), 32'h6);
        @(negedge clk);
        chk("redir_ir", 32'(ir_a), 32'h3664);
        chk("redir_ir_pc", 32'(irpc_a), 32'h6);
        pc_load = 1'b1; pc_target = 16'hFFFE;
        @(negedge clk);
        pc_load = 1'b0;
        chk("wrap_addr_pre", 32'(addr_a), 32'hFFFE);
        @(negedge clk);
        chk("wrap_ir_pc", 32'(irpc_a), 32'hFFFE);
        chk("wrap_ir", 32'(ir_a), 32'h5A5B);
        chk("wrap_addr", 32'(addr_a), 32'h0000);

        // Odd redirect target.
        pc_load = 1'b1; pc_target = 16'h0005;
        @(negedge clk);
        pc_load = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        chk("mis_fault", 32'(fault_a), 32'h1);
        chk("mis_valid", 32'(valid_a), 32'h0);
        chk("mis_addr", 32'(addr_a), 32'h0);
        pc_load = 1'b1; pc_target = 16'h0002;
        repeat (3) @(negedge clk);
        pc_load = 1'b0;
        chk("mis_sticky", 32'(fault_a), 32'h1);
        chk("mis_stuck_addr", 32'(addr_a), 32'h0);
`else
        chk("odd_addr", 32'(addr_a), 32'h4);
        chk("odd_fault", 32'(fault_a), 32'h0);
        @(negedge clk);
        chk("odd_ir", 32'(ir_a), 32'h2416);
        chk("odd_valid", 32'(valid_a), 32'h1);
`endif

        // Asynchronous reset while holding an instruction.
        do_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        chk("areset_pre", 32'(valid_a), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", 32'(valid_a), 32'h0);
        chk("areset_addr", 32'(addr_a), 32'h0);
        chk("areset_fault", 32'(fault_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 199) != 0);
            fetch_en = ($urandom_range(0, 3) != 0);
            ir_ready = $urandom_range(0, 1) == 1;
            pc_load  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) pc_target = 16'($urandom_range(0, 15));
            else                           pc_target = 16'($urandom);
            if ($urandom_range(0, 7) != 0) pc_target[0] = 1'b0;
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
